dwr_arb: RTL and testbench

- Round-robin/fixed-priority arbiter that shares one DDR write master among NUM_REQ burst requesters (frame grabbers L/R and similar).
- Grants one requester per burst and forwards its packet to the DDR write master through a registered mux. A packet is a cmd word, an addr word, then len data words.
- Tracks burst length, detects protocol errors, and exposes control, status and count registers on the internal bus.

---
 rtl/dwr_arb_if.sv | 30 +++
 rtl/dwr_arb.sv | 226 ++++++++++++++++++++++
 tb/tb_dwr_arb.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dwr_arb_if.sv
// Bundle of the internal register bus, requester streams and DDR write master stream for dwr_arb.
// Streams are valid-only: a word moves on every cycle its vout is high with no per-word backpressure; m_rdy gates whole bursts.
interface dwr_arb_if #(
  parameter int NUM_REQ = 2
);
  logic                    ibus_cs;
  logic                    ibus_wr;
  logic [7:0]              ibus_addr;
  logic [31:0]             ibus_wrdata;
  logic [31:0]             ibus_rddata;
  logic [NUM_REQ-1:0]      req_req;
  logic [NUM_REQ-1:0]      req_ack;
  logic [NUM_REQ*32-1:0]   req_dout;
  logic [NUM_REQ-1:0]      req_vout;
  logic                    m_rdy;
  logic [31:0]             m_dout;
  logic                    m_vout;
  logic                    m_sop;
  logic [1:0]              m_src;

  modport slave (
    input  ibus_cs, ibus_wr, ibus_addr, ibus_wrdata, req_req, req_dout, req_vout, m_rdy,
    output ibus_rddata, req_ack, m_dout, m_vout, m_sop, m_src
  );

  modport master (
    output ibus_cs, ibus_wr, ibus_addr, ibus_wrdata, req_req, req_dout, req_vout, m_rdy,
    input  ibus_rddata, req_ack, m_dout, m_vout, m_sop, m_src
  );
endinterface

// File: rtl/dwr_arb.sv
// Burst arbiter sharing one DDR write master among NUM_REQ requesters, with a registered forwarding mux
// and ctrl/status/burst-count registers. The FSM state is visible in status[1:0].
module dwr_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic     clk,
  input  logic     rst,
  dwr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DATA  = 2'd2,
    POST  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               enb_q, enb_d;
  logic               mode_q, mode_d;
  logic [3:0]         mask_q, mask_d;
  logic [1:0]         gid_q, gid_d;
  logic [1:0]         rr_q, rr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [8:0]         left_q, left_d;
  logic               addr_seen_q, addr_seen_d;
  logic [9:0]         idle_q, idle_d;
  logic               err_q, err_d;
  logic               perr_q, perr_d;
  logic [31:0]        bcnt_q, bcnt_d;
  logic [31:0]        mdout_q, mdout_d;
  logic               mvout_q, mvout_d;
  logic               msop_q, msop_d;
  logic [1:0]         msrc_q, msrc_d;

  logic               wr_en, sel_ctrl, sel_stat, sel_bcnt;
  logic [NUM_REQ-1:0] cand, gid_oh, win_oh;
  logic [3:0]         cand4;
  logic [1:0]         start, idx, win;
  logic               found;
  logic               sel_vout, stray, bcnt_inc;
  logic [31:0]        sel_dout;
  logic               unused_ok;

  assign wr_en    = bus.ibus_cs & bus.ibus_wr;
  assign sel_ctrl = (bus.ibus_addr[7:2] == 6'd0);
  assign sel_stat = (bus.ibus_addr[7:2] == 6'd1);
  assign sel_bcnt = (bus.ibus_addr[7:2] == 6'd2);
  assign unused_ok = ^{bus.ibus_addr[1:0], bus.ibus_wrdata[31:12], bus.ibus_wrdata[7:5], bus.ibus_wrdata[3:1]};

  assign cand  = bus.req_req & mask_q[NUM_REQ-1:0];
  assign cand4 = 4'(cand);
  assign start = mode_q ? 2'd0 : rr_q;

  // Rotating search from start; fixed mode just pins start at requester 0.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = 2'((int'(start) + k) % NUM_REQ);
      if (!found && cand4[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gid_oh   = '0;
    win_oh   = '0;
    sel_dout = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gid_oh[i] = (gid_q == 2'(i));
      win_oh[i] = (win == 2'(i));
      if (gid_q == 2'(i)) sel_dout = bus.req_dout[i*32 +: 32];
    end
  end

  assign sel_vout = |(bus.req_vout & gid_oh);
  assign stray    = (state_q == IDLE) ? (|bus.req_vout) : (|(bus.req_vout & ~gid_oh));

  always_comb begin
    state_d     = state_q;
    enb_d       = enb_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    gid_d       = gid_q;
    rr_d        = rr_q;
    ack_d       = '0;
    left_d      = left_q;
    addr_seen_d = addr_seen_q;
    idle_d      = idle_q;
    err_d       = err_q;
    perr_d      = perr_q;
    mdout_d     = mdout_q;
    mvout_d     = 1'b0;
    msop_d      = 1'b0;
    msrc_d      = msrc_q;
    bcnt_inc    = 1'b0;

    if (wr_en && sel_ctrl) begin
      enb_d  = bus.ibus_wrdata[0];
      mode_d = bus.ibus_wrdata[4];
      mask_d = bus.ibus_wrdata[11:8];
    end
    if (wr_en && sel_stat) begin
      err_d  = 1'b0;
      perr_d = 1'b0;
    end

    if (!enb_q) begin
      state_d = IDLE;
    end else begin
      if (stray) perr_d = 1'b1;
      if (state_q == GRANT || state_q == DATA) begin
        mvout_d = sel_vout;
        msrc_d  = gid_q;
        if (sel_vout) mdout_d = sel_dout;
      end
      case (state_q)
        IDLE: begin
          if (found && bus.m_rdy) begin
            gid_d   = win;
            rr_d    = 2'((int'(win) + 1) % NUM_REQ);
            ack_d   = win_oh;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (sel_vout) begin
            msop_d      = 1'b1;
            left_d      = 9'(sel_dout[7:0]) + 9'd1;
            addr_seen_d = 1'b0;
            idle_d      = '0;
            state_d     = DATA;
          end else begin
            perr_d  = 1'b1;
            state_d = POST;
          end
        end
        DATA: begin
          if (sel_vout) begin
            idle_d = '0;
            if (!addr_seen_q) begin
              addr_seen_d = 1'b1;
            end else begin
              left_d = left_q - 9'd1;
              if (left_q == 9'd1) begin
                bcnt_inc = 1'b1;
                state_d  = POST;
              end
            end
          end else if (idle_q == 10'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = POST;
          end else begin
            idle_d = idle_q + 10'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A software clear beats a same-cycle burst completion.
    if (wr_en && sel_bcnt) bcnt_d = '0;
    else                   bcnt_d = bcnt_q + 32'(bcnt_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enb_q       <= 1'b0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
      gid_q       <= '0;
      rr_q        <= '0;
      ack_q       <= '0;
      left_q      <= '0;
      addr_seen_q <= 1'b0;
      idle_q      <= '0;
      err_q       <= 1'b0;
      perr_q      <= 1'b0;
      bcnt_q      <= '0;
      mdout_q     <= '0;
      mvout_q     <= 1'b0;
      msop_q      <= 1'b0;
      msrc_q      <= '0;
    end else begin
      state_q     <= state_d;
      enb_q       <= enb_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      gid_q       <= gid_d;
      rr_q        <= rr_d;
      ack_q       <= ack_d;
      left_q      <= left_d;
      addr_seen_q <= addr_seen_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      perr_q      <= perr_d;
      bcnt_q      <= bcnt_d;
      mdout_q     <= mdout_d;
      mvout_q     <= mvout_d;
      msop_q      <= msop_d;
      msrc_q      <= msrc_d;
    end
  end

  always_comb begin
    bus.ibus_rddata = '0;
    if (bus.ibus_cs) begin
      if (sel_ctrl)      bus.ibus_rddata = {20'b0, mask_q, 3'b0, mode_q, 3'b0, enb_q};
      else if (sel_stat) bus.ibus_rddata = {22'b0, perr_q, err_q, 2'b0, gid_q, 2'b0, state_q};
      else if (sel_bcnt) bus.ibus_rddata = bcnt_q;
    end
  end

  assign bus.req_ack = ack_q;
  assign bus.m_dout  = mdout_q;
  assign bus.m_vout  = mvout_q;
  assign bus.m_sop   = msop_q;
  assign bus.m_src   = msrc_q;

endmodule

// File: tb/tb_dwr_arb.sv
// Directed bench for dwr_arb: requester driver tasks, forwarded-word scoreboard, register checks.
module tb_dwr_arb;
  localparam int NR = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dwr_arb_if #(.NUM_REQ(NR)) bus ();
  dwr_arb #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int fwd_cnt = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every forwarded word must match the head of exp_q as {sop, src, data}.
  always @(negedge clk) begin
    if (!rst && bus.m_vout === 1'b1) begin
      logic [34:0] obs, exp;
      obs = {bus.m_sop, bus.m_src, bus.m_dout};
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else                  exp = 'x;
      fwd_cnt++;
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL fwd_word: observed 0x%09h expected 0x%09h", obs, exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    bus.ibus_cs = 1'b1; bus.ibus_wr = 1'b1; bus.ibus_addr = a; bus.ibus_wrdata = d;
    tick();
    bus.ibus_cs = 1'b0; bus.ibus_wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d);
    bus.ibus_cs = 1'b1; bus.ibus_wr = 1'b0; bus.ibus_addr = a;
    #1;
    d = bus.ibus_rddata;
    bus.ibus_cs = 1'b0;
  endtask

  task automatic wait_ack(output int gid);
    gid = -1;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (bus.req_ack != '0) begin
        gid = bus.req_ack[1] ? 1 : 0;
        return;
      end
    end
  endtask

  task automatic drive_word(input int id, input logic [31:0] d, input logic sop);
    bus.req_vout = '0;
    bus.req_vout[id] = 1'b1;
    bus.req_dout[id*32 +: 32] = d;
    exp_q.push_back({sop, 2'(id), d});
  endtask

  // Called in the ack cycle; returns in the cycle after the last word sent, with vout low.
  task automatic send_body(input int id, input logic [7:0] len_m1, input int ndata, input int stray_at);
    drive_word(id, {16'hC0DE, 8'(id), len_m1}, 1'b1);
    tick();
    check("ack_pulse", 32'(bus.req_ack), 32'd0);
    drive_word(id, 32'h1000_0000 + 32'(id), 1'b0);
    tick();
    for (int i = 0; i < ndata; i++) begin
      drive_word(id, $urandom, 1'b0);
      if (i == stray_at) begin
        bus.req_vout[1-id] = 1'b1;
        bus.req_dout[(1-id)*32 +: 32] = 32'hBAD0_BAD0;
      end
      tick();
    end
    bus.req_vout = '0;
  endtask

  logic [31:0] rd;
  int g;

  initial begin
    rst = 1'b1;
    bus.ibus_cs = 1'b0; bus.ibus_wr = 1'b0; bus.ibus_addr = '0; bus.ibus_wrdata = '0;
    bus.req_req = '0; bus.req_dout = '0; bus.req_vout = '0; bus.m_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_ack", 32'(bus.req_ack), 32'd0);
    check("rst_mvout", 32'(bus.m_vout), 32'd0);
    check("rst_msop", 32'(bus.m_sop), 32'd0);
    check("rst_mdout", bus.m_dout, 32'd0);
    check("rst_msrc", 32'(bus.m_src), 32'd0);
    check("rddata_nocs", bus.ibus_rddata, 32'd0);
    rd_reg(8'h00, rd); check("rst_ctrl", rd, 32'd0);
    rd_reg(8'h04, rd); check("rst_status", rd, 32'd0);
    rd_reg(8'h08, rd); check("rst_bcnt", rd, 32'd0);

    // Single long burst from req0
    wr_reg(8'h00, 32'h0000_0301);
    rd_reg(8'h00, rd); check("ctrl_rb", rd, 32'h0000_0301);
    bus.m_rdy = 1'b1;
    bus.req_req = 2'b01;
    wait_ack(g); check("t1_gid", 32'(g), 32'd0);
    send_body(0, 8'd63, 64, -1);
    bus.req_req = '0;
    rd_reg(8'h04, rd); check("t1_post", 32'(rd[1:0]), 32'd3);
    tick();
    rd_reg(8'h04, rd); check("t1_idle", 32'(rd[1:0]), 32'd0);
    rd_reg(8'h08, rd); check("t1_bcnt", rd, 32'd1);
    check("t1_fwd_cnt", 32'(fwd_cnt), 32'd66);

    // m_rdy gating
    bus.m_rdy = 1'b0;
    bus.req_req = 2'b10;
    repeat (3) tick();
    check("rdy_noack", 32'(bus.req_ack), 32'd0);
    bus.m_rdy = 1'b1;
    tick();
    check("rdy_ack", 32'(bus.req_ack), 32'd2);
    send_body(1, 8'd3, 4, -1);
    bus.req_req = '0;
    tick();

    // Round robin with both requesting
    bus.req_req = 2'b11;
    for (int p = 0; p < 4; p++) begin
      wait_ack(g); check("rr_gid", 32'(g), 32'(p % 2));
      send_body(g, 8'd3, 4, -1);
      rd_reg(8'h04, rd); check("rr_post", 32'(rd[1:0]), 32'd3);
    end
    bus.req_req = '0;
    tick();
    rd_reg(8'h04, rd); check("rr_noperr", 32'(rd[9]), 32'd0);

    // Fixed priority
    wr_reg(8'h00, 32'h0000_0311);
    bus.req_req = 2'b11;
    for (int p = 0; p < 3; p++) begin
      wait_ack(g); check("fix_gid", 32'(g), 32'd0);
      send_body(g, 8'd3, 4, -1);
    end
    bus.req_req = '0;
    tick();
    rd_reg(8'h08, rd); check("bcnt_sum", rd, 32'd9);
    wr_reg(8'h08, 32'h0);
    rd_reg(8'h08, rd); check("bcnt_clr", rd, 32'd0);

    // Timeout: only 2 of 4 data words arrive
    bus.req_req = 2'b01;
    wait_ack(g); check("to_gid", 32'(g), 32'd0);
    send_body(0, 8'd3, 2, -1);
    bus.req_req = '0;
    repeat (15) tick();
    rd_reg(8'h04, rd); check("to_wait_state", 32'(rd[1:0]), 32'd2);
    check("to_wait_err", 32'(rd[8]), 32'd0);
    tick();
    rd_reg(8'h04, rd); check("to_post", 32'(rd[1:0]), 32'd3);
    check("to_err", 32'(rd[8]), 32'd1);
    tick();
    rd_reg(8'h04, rd); check("to_idle", 32'(rd[1:0]), 32'd0);
    rd_reg(8'h08, rd); check("to_bcnt", rd, 32'd0);
    wr_reg(8'h04, 32'h0);
    rd_reg(8'h04, rd); check("err_clr", 32'(rd[8]), 32'd0);

    // Stray vout from req1 while req0 owns the grant
    bus.req_req = 2'b01;
    wait_ack(g); check("pe_gid", 32'(g), 32'd0);
    send_body(0, 8'd3, 4, 1);
    bus.req_req = '0;
    rd_reg(8'h04, rd); check("pe_perr", 32'(rd[9]), 32'd1);
    check("pe_err", 32'(rd[8]), 32'd0);
    tick();
    wr_reg(8'h04, 32'h0);
    rd_reg(8'h04, rd); check("pe_clr", 32'(rd[9]), 32'd0);
    rd_reg(8'h08, rd); check("pe_bcnt", rd, 32'd1);

    tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
